// File: rtl/hazard_controller_if.sv
// hazard_controller_if
// Bundles every pipeline-facing signal of the hazard controller.
//   master : the pipeline side, drives register numbers, write enables, load /
//            branch / redirect / syscall indications and syscall_done; receives
//            stalls, flushes, forwarding selects, syscall_go and busy.
//   slave  : the hazard controller itself (directions mirrored).
interface hazard_controller_if;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [4:0] rs_e;
  logic [4:0] rt_e;
  logic [4:0] write_reg_e;
  logic [4:0] write_reg_m;
  logic [4:0] write_reg_w;
  logic       reg_write_e;
  logic       reg_write_m;
  logic       reg_write_w;
  logic       mem_to_reg_e;
  logic       mem_to_reg_m;
  logic       branch_d;
  logic       pc_src_d;
  logic       syscall_e;
  logic       syscall_done;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;
  logic [1:0] forward_a_e;
  logic [1:0] forward_b_e;
  logic       forward_a_d;
  logic       forward_b_d;
  logic       syscall_go;
  logic       busy;

  modport master (
    output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, pc_src_d, syscall_e, syscall_done,
    input  stall_f, stall_d, flush_d, flush_e, forward_a_e, forward_b_e,
           forward_a_d, forward_b_d, syscall_go, busy
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, pc_src_d, syscall_e, syscall_done,
    output stall_f, stall_d, flush_d, flush_e, forward_a_e, forward_b_e,
           forward_a_d, forward_b_d, syscall_go, busy
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller
// Stall / flush / forwarding decisions for the F, D and E stages of the
// five-stage pipeline, plus a RUN -> DRAIN -> SERVICE -> RESUME sequencer that
// drains the pipe on a syscall and hands over to the syscall service logic.
// Ports:
//   clk          clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   bus          hazard_controller_if.slave, all pipeline-facing signals
//   stall_count  (only with HAZARD_PERF_EN defined) saturating count of
//                cycles with stall_d high, cleared by rst
// Parameter DRAIN_CYCLES (1..7): cycles spent in DRAIN.
// Optional feature macro: HAZARD_PERF_EN.
module hazard_controller #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  hazard_controller_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_RESUME  = 2'd3;
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 32'd1);

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       lwstall_s, brstall_s, hazard_s;

  // Register 0 is hard-wired, so it never counts as a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [4:0] src, input logic rw_m,
                                           input logic [4:0] wr_m, input logic rw_w,
                                           input logic [4:0] wr_w);
    if (rw_m && reg_match(src, wr_m)) begin
      return 2'b10;
    end else if (rw_w && reg_match(src, wr_w)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Forwarding selects and raw hazard detection, independent of the sequencer state.
  always_comb begin
    bus.forward_a_e = fwd_sel_e(bus.rs_e, bus.reg_write_m, bus.write_reg_m,
                                bus.reg_write_w, bus.write_reg_w);
    bus.forward_b_e = fwd_sel_e(bus.rt_e, bus.reg_write_m, bus.write_reg_m,
                                bus.reg_write_w, bus.write_reg_w);
    bus.forward_a_d = bus.reg_write_m & reg_match(bus.rs_d, bus.write_reg_m);
    bus.forward_b_d = bus.reg_write_m & reg_match(bus.rt_d, bus.write_reg_m);
    lwstall_s = bus.mem_to_reg_e &
                (reg_match(bus.rs_d, bus.write_reg_e) | reg_match(bus.rt_d, bus.write_reg_e));
    // A compare-in-D branch cannot use an E result or a load still in M.
    brstall_s = bus.branch_d &
                ((bus.reg_write_e &
                  (reg_match(bus.rs_d, bus.write_reg_e) | reg_match(bus.rt_d, bus.write_reg_e))) |
                 (bus.mem_to_reg_m &
                  (reg_match(bus.rs_d, bus.write_reg_m) | reg_match(bus.rt_d, bus.write_reg_m))));
    hazard_s  = lwstall_s | brstall_s | bus.syscall_e;
  end

  // Sequencer state, drain counter and SERVICE entry flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Next-state logic of the syscall sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (bus.syscall_e) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_SERVICE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_SERVICE: begin
        if (bus.syscall_done) begin
          state_d = ST_RESUME;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      ST_RESUME: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    // Flag is set only on the transition into SERVICE, so syscall_go fires once.
    first_d = (state_d == ST_SERVICE) && (state_q != ST_SERVICE);
  end

  // Per-state stall / flush / handshake outputs.
  always_comb begin
    bus.stall_f = 1'b0;
    bus.stall_d = 1'b0;
    bus.flush_d = 1'b0;
    bus.flush_e = 1'b0;
    case (state_q)
      ST_RUN: begin
        bus.stall_f = hazard_s;
        bus.stall_d = hazard_s;
        bus.flush_e = hazard_s;
        bus.flush_d = bus.pc_src_d & ~hazard_s;
      end
      ST_DRAIN, ST_SERVICE: begin
        bus.stall_f = 1'b1;
        bus.stall_d = 1'b1;
        bus.flush_e = 1'b1;
      end
      ST_RESUME: begin
        // D/E still holds the syscall-era bubble contents; clear them once.
        bus.flush_e = 1'b1;
        bus.flush_d = bus.pc_src_d;
      end
      default: begin
        bus.stall_f = 1'b0;
      end
    endcase
    // Gated by rst so a reset landing on the first SERVICE cycle emits no pulse.
    bus.syscall_go = (state_q == ST_SERVICE) & first_q & ~rst;
    bus.busy       = (state_q != ST_RUN);
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q;

  // Saturating count of cycles in which decode is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= 32'd0;
    end else if (bus.stall_d && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end else begin
      stall_count_q <= stall_count_q;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_hazard_controller;
  localparam int DRAIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_controller_if hif ();
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count;
`endif

  hazard_controller #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count (stall_count)
`endif
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] r, input logic rwm, input logic [4:0] wm,
                                     input logic rww, input logic [4:0] ww);
    if (rwm && hit(r, wm)) return 2'b10;
    if (rww && hit(r, ww)) return 2'b01;
    return 2'b00;
  endfunction

  // Model: pending drain cycles, in-service flag, first-service flag, resume flag.
  int          m_drain = 0;
  bit          m_svc = 1'b0;
  bit          m_first = 1'b0;
  bit          m_res = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  logic e_stall, e_fle, e_fld, e_go, e_busy, e_hz, m_run;
  logic [1:0] e_fa, e_fb;
  logic e_fad, e_fbd;

  always_comb begin
    m_run = (m_drain == 0) && !m_svc && !m_res;
    e_hz = (hif.mem_to_reg_e && (hit(hif.rs_d, hif.write_reg_e) || hit(hif.rt_d, hif.write_reg_e)))
        || (hif.branch_d && ((hif.reg_write_e && (hit(hif.rs_d, hif.write_reg_e) || hit(hif.rt_d, hif.write_reg_e)))
                          || (hif.mem_to_reg_m && (hit(hif.rs_d, hif.write_reg_m) || hit(hif.rt_d, hif.write_reg_m)))))
        || hif.syscall_e;
    e_stall = m_run ? e_hz : !m_res;
    e_fle   = m_run ? e_hz : 1'b1;
    e_fld   = (m_run || m_res) ? (hif.pc_src_d && !e_stall) : 1'b0;
    e_go    = m_svc && m_first && !rst;
    e_busy  = !m_run;
    e_fa  = fwd(hif.rs_e, hif.reg_write_m, hif.write_reg_m, hif.reg_write_w, hif.write_reg_w);
    e_fb  = fwd(hif.rt_e, hif.reg_write_m, hif.write_reg_m, hif.reg_write_w, hif.write_reg_w);
    e_fad = hif.reg_write_m && hit(hif.rs_d, hif.write_reg_m);
    e_fbd = hif.reg_write_m && hit(hif.rt_d, hif.write_reg_m);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_drain <= 0; m_svc <= 1'b0; m_first <= 1'b0; m_res <= 1'b0; m_cnt <= 32'd0;
    end else begin
      if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
      if (m_res) m_res <= 1'b0;
      else if (m_svc) begin
        m_first <= 1'b0;
        if (hif.syscall_done) begin m_svc <= 1'b0; m_res <= 1'b1; end
      end else if (m_drain > 0) begin
        m_drain <= m_drain - 1;
        if (m_drain == 1) begin m_svc <= 1'b1; m_first <= 1'b1; end
      end else if (hif.syscall_e) m_drain <= DRAIN;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("stall_f", hif.stall_f, e_stall);
      check_val("stall_d", hif.stall_d, e_stall);
      check_val("flush_e", hif.flush_e, e_fle);
      check_val("flush_d", hif.flush_d, e_fld);
      check_val("fwd_a_e", hif.forward_a_e, e_fa);
      check_val("fwd_b_e", hif.forward_b_e, e_fb);
      check_val("fwd_a_d", hif.forward_a_d, e_fad);
      check_val("fwd_b_d", hif.forward_b_d, e_fbd);
      check_val("syscall_go", hif.syscall_go, e_go);
      check_val("busy", hif.busy, e_busy);
`ifdef HAZARD_PERF_EN
      check_val("stall_count", stall_count, m_cnt);
`endif
    end
  end

  task automatic quiet();
    hif.rs_d = 5'd0; hif.rt_d = 5'd0; hif.rs_e = 5'd0; hif.rt_e = 5'd0;
    hif.write_reg_e = 5'd0; hif.write_reg_m = 5'd0; hif.write_reg_w = 5'd0;
    hif.reg_write_e = 1'b0; hif.reg_write_m = 1'b0; hif.reg_write_w = 1'b0;
    hif.mem_to_reg_e = 1'b0; hif.mem_to_reg_m = 1'b0; hif.branch_d = 1'b0;
    hif.pc_src_d = 1'b0; hif.syscall_e = 1'b0; hif.syscall_done = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int busy_n, go_n, go_at, held;

  initial begin
    quiet();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("go_in_reset", hif.syscall_go, 1'b0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check_val("rst_busy", hif.busy, 1'b0);
    check_val("rst_stall", hif.stall_d, 1'b0);
    check_val("rst_flush_e", hif.flush_e, 1'b0);
    check_val("rst_go", hif.syscall_go, 1'b0);

    // E forwarding priority and register 0
    step();
    hif.rs_e = 5'd5; hif.write_reg_m = 5'd5; hif.reg_write_m = 1'b1;
    hif.write_reg_w = 5'd5; hif.reg_write_w = 1'b1;
    @(negedge clk); check_val("fwd_m_wins", hif.forward_a_e, 2'b10);
    step(); hif.reg_write_m = 1'b0;
    @(negedge clk); check_val("fwd_w", hif.forward_a_e, 2'b01);
    step(); hif.rs_e = 5'd0;
    @(negedge clk); check_val("fwd_r0", hif.forward_a_e, 2'b00);

    // load-use stall, redirect suppressed
    step(); quiet();
    hif.mem_to_reg_e = 1'b1; hif.write_reg_e = 5'd8; hif.rt_d = 5'd8;
    @(negedge clk);
    check_val("lw_stall_f", hif.stall_f, 1'b1);
    check_val("lw_flush_e", hif.flush_e, 1'b1);
    step(); hif.pc_src_d = 1'b1;
    @(negedge clk); check_val("lw_flush_d", hif.flush_d, 1'b0);

    // branch hazard then forward from M
    step(); quiet();
    hif.branch_d = 1'b1; hif.rs_d = 5'd3; hif.reg_write_e = 1'b1; hif.write_reg_e = 5'd3;
    @(negedge clk); check_val("br_stall", hif.stall_d, 1'b1);
    step(); hif.reg_write_e = 1'b0; hif.write_reg_e = 5'd0;
    hif.write_reg_m = 5'd3; hif.reg_write_m = 1'b1; hif.mem_to_reg_m = 1'b0;
    @(negedge clk);
    check_val("br_nostall", hif.stall_d, 1'b0);
    check_val("br_fwd_a_d", hif.forward_a_d, 1'b1);

    // syscall with immediate completion
    step(); quiet(); hif.syscall_done = 1'b1; hif.syscall_e = 1'b1;
    @(negedge clk); check_val("sys_detect", hif.stall_d, 1'b1);
    busy_n = 0; go_n = 0; go_at = 0;
    for (int k = 1; k <= 5; k++) begin
      step(); hif.syscall_e = 1'b0;
      @(negedge clk);
      if (hif.busy) busy_n++;
      if (hif.syscall_go) begin go_n++; go_at = k; end
      if (k == 4) check_val("resume_flush_e", hif.flush_e, 1'b1);
      if (k == 5) check_val("run_at_5", hif.busy, 1'b0);
    end
    check_val("busy_cycles", busy_n, 4);
    check_val("go_count", go_n, 1);
    check_val("go_cycle", go_at, 3);

    // long service then reset mid-SERVICE
    step(); quiet(); hif.syscall_e = 1'b1;
    go_n = 0; held = 1;
    for (int k = 1; k <= 12; k++) begin
      step(); hif.syscall_e = 1'b0;
      @(negedge clk);
      if (hif.syscall_go) go_n++;
      if (!hif.stall_f || !hif.stall_d) held = 0;
    end
    check_val("svc_go_once", go_n, 1);
    check_val("svc_held", held, 1);
    step(); rst = 1'b1;
    @(negedge clk); check_val("rst_svc_go", hif.syscall_go, 1'b0);
    step(); rst = 1'b0;
    @(negedge clk);
    check_val("rst_svc_busy", hif.busy, 1'b0);
    check_val("rst_svc_go2", hif.syscall_go, 1'b0);

    // reset landing on the first SERVICE cycle suppresses the pulse
    step(); hif.syscall_e = 1'b1;
    step(); hif.syscall_e = 1'b0;
    step();
    step(); rst = 1'b1;
    @(negedge clk); check_val("rst_first_go", hif.syscall_go, 1'b0);
    step(); rst = 1'b0;
    @(negedge clk); check_val("rst_first_busy", hif.busy, 1'b0);

`ifdef HAZARD_PERF_EN
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    hif.mem_to_reg_e = 1'b1; hif.write_reg_e = 5'd8; hif.rt_d = 5'd8;
    step(); step();
    step(); quiet(); hif.syscall_done = 1'b1; hif.syscall_e = 1'b1;
    step(); hif.syscall_e = 1'b0;
    repeat (6) step();
    @(negedge clk); check_val("perf_count", stall_count, 32'd7);
`endif

    // randomized traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      hif.rs_d = 5'($urandom_range(0, 3)); hif.rt_d = 5'($urandom_range(0, 3));
      hif.rs_e = 5'($urandom_range(0, 3)); hif.rt_e = 5'($urandom_range(0, 3));
      hif.write_reg_e = 5'($urandom_range(0, 3));
      hif.write_reg_m = 5'($urandom_range(0, 3));
      hif.write_reg_w = 5'($urandom_range(0, 3));
      hif.reg_write_e = 1'($urandom); hif.reg_write_m = 1'($urandom);
      hif.reg_write_w = 1'($urandom); hif.mem_to_reg_e = 1'($urandom);
      hif.mem_to_reg_m = 1'($urandom); hif.branch_d = 1'($urandom);
      hif.pc_src_d = 1'($urandom);
      hif.syscall_e = ($urandom_range(0, 7) == 0);
      hif.syscall_done = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    step(); rst = 1'b0; quiet();
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central hazard and sequencing controller for the five-stage pipelined CPU. Each cycle it decides stalls, flushes and operand forwarding for the F/D/E stages, and drives the synchronous clear (`sig_clr`) of the decode-to-execute pipeline register. It also runs a small state machine that drains the pipeline on a `syscall` and hands control to the external syscall service logic until that logic signals completion.

## Interface
- `DRAIN_CYCLES`, default 2: cycles spent in DRAIN so that older instructions retire through M and W. Legal range 1–7.

- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `rs_d`, `rt_d`  in  5 each  source register numbers in Decode
- `rs_e`, `rt_e`  in  5 each  source register numbers in Execute
- `write_reg_e`, `write_reg_m`, `write_reg_w`  in  5 each  destination register per stage
- `reg_write_e`, `reg_write_m`, `reg_write_w`  in  1 each  register write enable per stage
- `mem_to_reg_e`, `mem_to_reg_m`  in  1 each  the instruction in that stage is a load
- `branch_d`  in  1  branch in Decode that compares operands
- `pc_src_d`  in  1  taken branch or jump redirect, resolved in Decode
- `syscall_e`  in  1  syscall instruction in Execute
- `syscall_done`  in  1  service logic has finished
- `stall_f`, `stall_d`  out  1 each  hold the PC and the F/D register
- `flush_d`  out  1  clear the F/D register
- `flush_e`  out  1  clear the D/E register; connects to its `sig_clr`
- `forward_a_e`, `forward_b_e`  out  2 each  ALU operand select: 00 = register file, 01 = W result, 10 = M ALU result
- `forward_a_d`, `forward_b_d`  out  1 each  branch comparator takes the M ALU result
- `syscall_go`  out  1  one-cycle request to the service logic
- `busy`  out  1  state machine is not in RUN

## Operation
- A register match always requires a nonzero register number. Register 0 never matches and is never forwarded.
- **E forwarding:** 10 if `reg_write_m` and `write_reg_m` matches; otherwise 01 if `reg_write_w` and `write_reg_w` matches; otherwise 00. When both M and W match, M wins.
- **D forwarding:** `forward_x_d` = `reg_write_m` and `write_reg_m` matches `rs_d`/`rt_d`.
- **Load-use hazard (`lwstall`):** `mem_to_reg_e` and `write_reg_e` matches `rs_d` or `rt_d`.
- **Branch hazard (`brstall`):** `branch_d` and either
  - `reg_write_e` and `write_reg_e` matches `rs_d`/`rt_d`, or
  - `mem_to_reg_m` and `write_reg_m` matches `rs_d`/`rt_d`.
- **States:** RUN, DRAIN, SERVICE, RESUME. State is encoded in 2 bits; the drain counter is 3 bits.
- **RUN:**
  - `stall_f` = `stall_d` = `flush_e` = `lwstall` | `brstall` | `syscall_e`.
  - `flush_d` = `pc_src_d` & ~`stall_d`.
  - If `syscall_e` → DRAIN, with counter loaded to `DRAIN_CYCLES`−1.
- **DRAIN:**
  - `stall_f`, `stall_d` and `flush_e` are held at 1 and `flush_d` is 0.
  - The counter decrements each cycle. When the counter is 0 → SERVICE.
- **SERVICE:**
  - Stalls and `flush_e` stay held at 1.
  - `syscall_go` = 1 only on the first SERVICE cycle, using a registered entry flag.
  - `syscall_done` is sampled on every SERVICE cycle, including the first. When it is 1 → RESUME.
- **RESUME:**
  - Stalls are 0. `flush_e` = 1 for this one cycle, so the stale D/E contents are not re-executed.
  - Always → RUN.
- `busy` = (state ≠ RUN).
- Forwarding outputs are computed in every state.
- **Ignored inputs:**
  - `syscall_done` outside SERVICE.
  - `syscall_e` outside RUN.
  - `pc_src_d` while `stall_d` = 1.

## Timing
- Hazard, forwarding and stall outputs are combinational from the inputs and the current state, and are valid in the same cycle. There is no registered latency.
- The syscall sequence runs as follows:
  - Cycle 0: detection in RUN.
  - Cycles 1 to `DRAIN_CYCLES`: DRAIN.
  - Cycle `DRAIN_CYCLES`+1: first SERVICE cycle, with `syscall_go` pulsed.
  - Minimum total is `DRAIN_CYCLES`+3 cycles, reached when `syscall_done` = 1 on the first SERVICE cycle.
- **Reset:**
  - State → RUN, counter → 0, entry flag cleared.
  - All outputs go to 0 as soon as the state is RUN and the inputs are quiet.
  - `syscall_go` is 0 during reset and in the cycle after it.
  - Reset in any state (including in the middle of SERVICE) aborts the sequence with no `syscall_go` pulse.

## Configuration
- `HAZARD_PERF_EN`: when defined, adds an output `stall_count` (32 bits).
  - It increments on every cycle where `stall_d` = 1 and saturates at 0xFFFFFFFF.
  - It is cleared by `rst`.
- When undefined, the port and the counter are absent and the block is otherwise identical.

## Test plan
- `rs_e`=5; `write_reg_m`=5, `reg_write_m`=1; `write_reg_w`=5, `reg_write_w`=1 → `forward_a_e`=10. Then drop `reg_write_m` → `forward_a_e`=01. Then set `rs_e`=0 → 00.
- `mem_to_reg_e`=1, `write_reg_e`=8, `rt_d`=8 → `stall_f`=`stall_d`=`flush_e`=1 in the same cycle. Add `pc_src_d`=1 → `flush_d`=0.
- `branch_d`=1, `rs_d`=3, `reg_write_e`=1, `write_reg_e`=3 → stall. Move the producer to M with `reg_write_m`=1, `mem_to_reg_m`=0 → no stall and `forward_a_d`=1.
- `syscall_e` pulse with `DRAIN_CYCLES`=2, `syscall_done` tied to 1 →
  - `busy` is high for 4 cycles;
  - `syscall_go` is high for exactly 1 cycle, the 3rd after detection;
  - `flush_e`=1 in the RESUME cycle;
  - RUN is reached on cycle 5.
- `syscall_done` held at 0 for 10 SERVICE cycles → stalls are held and `syscall_go` is not repeated. Assert `rst` during SERVICE → RUN next cycle, `busy`=0, no `syscall_go`.
- With `HAZARD_PERF_EN` defined: 3 load-use stall cycles followed by one syscall (`DRAIN_CYCLES`=2, `syscall_done`=1 on the first SERVICE cycle) → `stall_count`=7.
